ram_responder: RTL and testbench

//  Single-port synchronous RAM slave: the responder side of the write/read port a bench or master drives.
//  - Accepts one request per clock through a valid/ready handshake.
//  - Reads are fully pipelined with a fixed 2-cycle latency.
//  - After every reset it self-clears the whole array before accepting traffic.

---
 rtl/ram_responder_if.sv | 39 +++
 rtl/ram_responder.sv | 107 ++++++++++
 tb/tb_ram_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// Request/response bundle between a master and ram_responder.
//   master : drives req_valid, we, addr, datain (and err_inject with parity)
//   slave  : drives req_ready, dataout, rd_valid, busy (and par_err with parity)
// Optional parity signals exist only when RAM_PARITY_EN is defined.
interface ram_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              rd_valid;
  logic              busy;
`ifdef RAM_PARITY_EN
  logic              err_inject;
  logic              par_err;
`endif

  modport master (
`ifdef RAM_PARITY_EN
    output err_inject,
    input  par_err,
`endif
    output req_valid, we, addr, datain,
    input  req_ready, dataout, rd_valid, busy
  );

  modport slave (
`ifdef RAM_PARITY_EN
    input  err_inject,
    output par_err,
`endif
    input  req_valid, we, addr, datain,
    output req_ready, dataout, rd_valid, busy
  );
endinterface

// File: rtl/ram_responder.sv
// Single-port synchronous RAM responder.
//   - valid/ready request port, one transfer per clock, no backpressure once idle
//   - reads pipelined, fixed 2-cycle latency (addr reg -> array sample -> output reg)
//   - after every reset the whole array is cleared, one word per cycle
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ram_responder_if.slave (req_valid/req_ready/we/addr/datain in,
//          dataout/rd_valid/busy out; err_inject/par_err with parity)
// Optional feature macro: RAM_PARITY_EN -- stores an even-parity bit per word,
//   adds err_inject (flip stored parity on write) and par_err (read check).
module ram_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  ram_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [MEM_W-1:0]  mem [DEPTH];

  // vld_pipe[0]: address stage holds a read; vld_pipe[1]: data stage holds a read
  logic [1:0]        vld_pipe;
  logic [ADDR_W-1:0] s1_addr;
  logic [MEM_W-1:0]  s2_word;

  logic              xfer;
  logic [MEM_W-1:0]  wr_word;

  assign xfer = bus.req_valid & bus.req_ready;

`ifdef RAM_PARITY_EN
  assign wr_word = {(^bus.datain) ^ bus.err_inject, bus.datain};
`else
  assign wr_word = bus.datain;
`endif

  // Clear sequencer; busy/req_ready are registered and flip on the edge
  // that writes the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      bus.busy      <= 1'b1;
      bus.req_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: begin
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array and read datapath carry no reset: the clear sequence initialises
  // the array, and vld_pipe decides whether the datapath contents matter.
  // s2_word samples with nonblocking semantics, so a write on the same edge
  // is not seen (read-before-write).
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_ptr] <= '0;
    else if (xfer && bus.we)
      mem[bus.addr] <= wr_word;
    if (xfer && !bus.we)
      s1_addr <= bus.addr;
    s2_word <= mem[s1_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      bus.rd_valid <= 1'b0;
      bus.dataout  <= '0;
`ifdef RAM_PARITY_EN
      bus.par_err  <= 1'b0;
`endif
    end else begin
      vld_pipe     <= {vld_pipe[0], xfer & ~bus.we};
      bus.rd_valid <= vld_pipe[1];
      if (vld_pipe[1])
        bus.dataout <= s2_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
      bus.par_err  <= vld_pipe[1] & (s2_word[DATA_W] ^ (^s2_word[DATA_W-1:0]));
`endif
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_responder #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    bit         perr;
    int         due;
  } rd_exp_t;

  typedef struct {
    bit         v;
    bit         we;
    logic [3:0] addr;
    logic [7:0] d;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         nrd = 0;
  logic [7:0] model [16];
  bit         bad [16];
  logic [7:0] last_d = '0;
  rd_exp_t    q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit w, input logic [3:0] a, input logic [7:0] d, input bit inj);
    bus.req_valid = v;
    bus.we        = w;
    bus.addr      = a;
    bus.datain    = d;
`ifdef RAM_PARITY_EN
    bus.err_inject = inj;
`endif
  endtask

  // One clock: apply a request, take the edge, then check the outputs
  // against the expected-read queue.
  task automatic step(input bit v, input bit w, input logic [3:0] a, input logic [7:0] d, input bit inj);
    bit      xfer;
    bit      rv;
    rd_exp_t e;
    drive(v, w, a, d, inj);
    xfer = v && (bus.req_ready === 1'b1);
    @(posedge clk);
    cyc++;
    if (xfer && w) begin
      model[a] = d;
      bad[a]   = inj;
    end else if (xfer) begin
      e.d = model[a]; e.perr = bad[a]; e.due = cyc + 2;
      q.push_back(e);
    end
    #1;
    rv = (q.size() > 0) && (q[0].due == cyc);
    chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, rv});
    if (rv) begin
      chk("dataout", {24'b0, bus.dataout}, {24'b0, q[0].d});
`ifdef RAM_PARITY_EN
      chk("par_err", {31'b0, bus.par_err}, {31'b0, q[0].perr});
`endif
      last_d = q[0].d;
      nrd++;
      void'(q.pop_front());
    end else begin
      chk("dataout_hold", {24'b0, bus.dataout}, {24'b0, last_d});
`ifdef RAM_PARITY_EN
      chk("par_err_idle", {31'b0, bus.par_err}, 32'd0);
`endif
    end
    drive(0, 0, '0, '0, 0);
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks reset values,
  // releases, and measures the clear duration.
  task automatic apply_reset();
    int n;
    drive(0, 0, '0, '0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd1);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("rst_dataout", {24'b0, bus.dataout}, 32'd0);
    q.delete();
    last_d = '0;
    for (int i = 0; i < 16; i++) begin model[i] = '0; bad[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      cyc++;
      if (bus.busy === 1'b1) chk("ready_in_clear", {31'b0, bus.req_ready}, 32'd0);
      if (bus.rd_valid !== 1'b0) chk("rd_valid_in_clear", {31'b0, bus.rd_valid}, 32'd0);
    end
    chk("clear_cycles", n, 32'd16);
    chk("ready_after_clear", {31'b0, bus.req_ready}, 32'd1);
    chk("busy_after_clear", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i), '0, 0);
    step(0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);
  endtask

  vec_t vt[8];
  int   n0;

  initial begin
    drive(0, 0, '0, '0, 0);
    @(posedge clk);
    #1;

    // Reset, clear timing, all-zero array
    apply_reset();
    read_all();
    for (int i = 0; i < 16; i++) chk("zero_model", {24'b0, model[i]}, 32'd0);

    // Write-then-read and read-before-write sequences
    vt[0] = '{1, 1, 4'd3, 8'hA5, 0, 8'h00};
    vt[1] = '{1, 0, 4'd3, 8'h00, 0, 8'h00};
    vt[2] = '{1, 1, 4'd7, 8'h11, 0, 8'h00};
    vt[3] = '{1, 0, 4'd7, 8'h00, 1, 8'hA5};
    vt[4] = '{1, 1, 4'd7, 8'h22, 0, 8'h00};
    vt[5] = '{1, 0, 4'd7, 8'h00, 1, 8'h11};
    vt[6] = '{0, 0, 4'd0, 8'h00, 0, 8'h00};
    vt[7] = '{0, 0, 4'd0, 8'h00, 1, 8'h22};
    for (int i = 0; i < 8; i++) begin
      step(vt[i].v, vt[i].we, vt[i].addr, vt[i].d, 0);
      if (vt[i].chk) begin
        chk("vec_rd_valid", {31'b0, bus.rd_valid}, 32'd1);
        chk("vec_data", {24'b0, bus.dataout}, {24'b0, vt[i].exp});
      end
    end

    // 20 random writes, then 16 back-to-back reads
    for (int i = 0; i < 20; i++)
      step(1, 1, 4'($urandom_range(0, 15)), 8'($urandom), 0);
    n0 = nrd;
    read_all();
    chk("b2b_count", nrd - n0, 32'd16);

    // Random interleaved traffic with idle gaps
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 7) == 0);
    step(0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);

    // Parity: corrupted word then clean word
    step(1, 1, 4'd5, 8'h0F, 1);
    step(1, 0, 4'd5, 8'h00, 0);
    step(1, 1, 4'd6, 8'h3C, 0);
    step(1, 0, 4'd6, 8'h00, 0);
`ifdef RAM_PARITY_EN
    chk("par_err_injected", {31'b0, bus.par_err}, 32'd1);
`endif
    step(0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);
`ifdef RAM_PARITY_EN
    chk("par_err_clean", {31'b0, bus.par_err}, 32'd0);
`endif

    // Reset with two reads in flight: both must vanish
    step(1, 1, 4'd9, 8'h5A, 0);
    step(1, 0, 4'd9, 8'h00, 0);
    step(1, 0, 4'd9, 8'h00, 0);
    apply_reset();
    read_all();

    if (q.size() != 0) chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
